freq_meter: RTL and testbench

FREQ_METER -- requirements
Module: freq_meter

---
 rtl/freq_meter_pkg.sv | 16 +
 rtl/freq_meter_sync.sv | 29 ++
 rtl/freq_meter.sv | 119 +++++++++++
 tb/tb_freq_meter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter.
//   fm_state_e      : measurement FSM states (IDLE, GATE, DONE)
//   GATE_CYCLES_DEF : default gate window length in clk cycles (1 s at 50 MHz)
//   CNT_W_DEF       : default width of the edge count result
package freq_meter_pkg;

  localparam int GATE_CYCLES_DEF = 50_000_000;
  localparam int CNT_W_DEF       = 27;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GATE = 2'd1,
    ST_DONE = 2'd2
  } fm_state_e;

endpackage

// File: rtl/freq_meter_sync.sv
// Two-flop synchronizer plus one history flop for rising-edge detection.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   async_in   : signal asynchronous to clk
//   edge_out   : one-cycle pulse per synchronized rising edge
module freq_meter_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic edge_out
);

  logic sync1, sync2, prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= async_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign edge_out = sync2 & ~prev;

endmodule

// File: rtl/freq_meter.sv
// Gated frequency meter: on a start request, counts rising edges of sig_in
// over a window of exactly GATE_CYCLES clk cycles and presents the count
// with a valid/ack handshake.
// Parameters:
//   GATE_CYCLES : gate window length in clk cycles (>= 2)
//   CNT_W       : width of the edge count result
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   sig_in      : measured signal (asynchronous)
//   start       : single-cycle request to start a measurement (IDLE only)
//   meas_ack    : consumer acknowledge of the pending result
//   meas_count  : edge count of the last completed window (held after ack)
//   meas_valid  : meas_count holds a new, unacknowledged result
//   busy        : measurement in progress or result pending
//   overflow    : only with FREQ_METER_OVF_EN defined; an edge arrived while
//                 the counter was saturated (counter saturates instead of
//                 wrapping in that build)
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = GATE_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  input  logic             start,
  input  logic             meas_ack,
  output logic [CNT_W-1:0] meas_count,
  output logic             meas_valid,
  output logic             busy
`ifdef FREQ_METER_OVF_EN
  ,output logic            overflow
`endif
);

  localparam int GW = (GATE_CYCLES > 2) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

  fm_state_e        state;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt;
  logic [CNT_W-1:0] edge_nxt;
  logic             edge_det;

  freq_meter_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (sig_in),
    .edge_out (edge_det)
  );

`ifdef FREQ_METER_OVF_EN
  logic ovf_acc;
  logic sat_hit;

  // Saturate at all-ones; remember any edge that was lost to saturation.
  assign sat_hit  = edge_det & (&edge_cnt);
  assign edge_nxt = (edge_det && !(&edge_cnt)) ? edge_cnt + 1'b1 : edge_cnt;
`else
  assign edge_nxt = edge_cnt + CNT_W'(edge_det);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      meas_count <= '0;
      meas_valid <= 1'b0;
`ifdef FREQ_METER_OVF_EN
      ovf_acc    <= 1'b0;
      overflow   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_GATE;
            gate_cnt <= '0;
            edge_cnt <= '0;
`ifdef FREQ_METER_OVF_EN
            ovf_acc  <= 1'b0;
`endif
          end
        end
        ST_GATE: begin
          edge_cnt <= edge_nxt;
          gate_cnt <= gate_cnt + 1'b1;
`ifdef FREQ_METER_OVF_EN
          ovf_acc  <= ovf_acc | sat_hit;
`endif
          // Last window cycle: its own edge is folded into the result.
          if (gate_cnt == GATE_LAST) begin
            meas_count <= edge_nxt;
            meas_valid <= 1'b1;
`ifdef FREQ_METER_OVF_EN
            overflow   <= ovf_acc | sat_hit;
`endif
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (meas_ack) begin
            meas_valid <= 1'b0;
`ifdef FREQ_METER_OVF_EN
            overflow   <= 1'b0;
`endif
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter (GATE_CYCLES=100, CNT_W=5). The
// reference counts rising transitions in the recorded per-cycle sample
// history of sig_in over the window the DUT observes (two-cycle
// synchronizer latency), then applies wrap or saturation arithmetic.
// Build with FREQ_METER_OVF_EN to cover the saturating variant.
module tb_freq_meter;

  localparam int G     = 100;
  localparam int CW    = 5;
  localparam int MAXV  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          sig_in;
  logic          start;
  logic          meas_ack;
  logic [CW-1:0] meas_count;
  logic          meas_valid;
  logic          busy;
`ifdef FREQ_METER_OVF_EN
  logic          overflow;
`endif

  freq_meter #(.GATE_CYCLES(G), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .sig_in     (sig_in),
    .start      (start),
    .meas_ack   (meas_ack),
    .meas_count (meas_count),
    .meas_valid (meas_valid),
    .busy       (busy)
`ifdef FREQ_METER_OVF_EN
    ,.overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // sig_in sampled at every rising edge, indexed by edge number
  bit hist [0:19999];
  int cyc = 0;
  always @(posedge clk) begin
    hist[cyc] <= sig_in;
    cyc       <= cyc + 1;
  end

  // sig_in generator: 0 = constant, 1 = square wave, 2 = random density
  int mode = 0, cval = 0, per = 10, dens = 50, ph = 0;
  always @(negedge clk) begin
    ph <= ph + 1;
    case (mode)
      0:       sig_in <= cval[0];
      1:       sig_in <= ((ph % per) < (per / 2));
      default: sig_in <= ($urandom_range(99) < dens);
    endcase
  end

  // Rising transitions seen by the DUT for a start sampled at edge t0.
  function automatic int ref_edges(input int t0);
    int n = 0;
    for (int i = t0 - 1; i <= t0 + G - 2; i++)
      if (hist[i] && !hist[i-1]) n++;
    return n;
  endfunction

  function automatic int ref_count(input int n);
`ifdef FREQ_METER_OVF_EN
    return (n > MAXV) ? MAXV : n;
`else
    return n % (MAXV + 1);
`endif
  endfunction

  // One full measurement. Optional fixed expectation (exp_n >= 0) on top
  // of the model; noise injects start pulses in GATE/DONE and a stray ack.
  task automatic run_meas(input string tag, input int exp_n, input bit noise);
    int t0, n;
    int res;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 t0 = cyc - 1;
    for (int k = 1; k < G; k++) begin
      @(negedge clk);
      start = noise && (k == 20 || k == 21 || k == 70);
      if (k == 50) chk({tag, "_busy_gate"}, busy, 1);
      @(posedge clk);
    end
    #1 chk({tag, "_valid_early"}, meas_valid, 0);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_valid_rise"}, meas_valid, 1);
    n   = ref_edges(t0);
    res = ref_count(n);
    chk({tag, "_count"}, meas_count, res);
    if (exp_n >= 0) chk({tag, "_count_fixed"}, meas_count, exp_n);
`ifdef FREQ_METER_OVF_EN
    chk({tag, "_ovf"}, overflow, (n > MAXV) ? 1 : 0);
`endif
    if (noise) begin
      for (int k = 0; k < 6; k++) begin
        @(negedge clk); start = (k < 3);
      end
      @(negedge clk); start = 1'b0;
      chk({tag, "_done_hold_v"}, meas_valid, 1);
      chk({tag, "_done_hold_c"}, meas_count, res);
    end
    @(negedge clk); meas_ack = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_ack_valid"}, meas_valid, 0);
    chk({tag, "_ack_busy"}, busy, 0);
`ifdef FREQ_METER_OVF_EN
    chk({tag, "_ack_ovf"}, overflow, 0);
`endif
    @(negedge clk); meas_ack = 1'b0;
    if (noise) begin
      // ack while idle must not disturb anything
      @(negedge clk); meas_ack = 1'b1;
      @(negedge clk); meas_ack = 1'b0;
      repeat (3) @(negedge clk);
      chk({tag, "_idle_ack_busy"}, busy, 0);
      chk({tag, "_idle_ack_valid"}, meas_valid, 0);
    end
    chk({tag, "_retain"}, meas_count, res);
  endtask

  initial begin
    int saw_valid;
    reset = 1'b1; start = 1'b0; meas_ack = 1'b0; sig_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_count", meas_count, 0);
    chk("rst_valid", meas_valid, 0);
    chk("rst_busy", busy, 0);
`ifdef FREQ_METER_OVF_EN
    chk("rst_ovf", overflow, 0);
`endif
    reset = 1'b0;
    repeat (5) @(negedge clk);

    mode = 1; per = 10;
    repeat (12) @(negedge clk);
    run_meas("sq10", 10, 1'b0);

    mode = 0; cval = 1;
    repeat (12) @(negedge clk);
    run_meas("const1", 0, 1'b0);

    mode = 1; per = 2;
    repeat (12) @(negedge clk);
`ifdef FREQ_METER_OVF_EN
    run_meas("sq2", 31, 1'b0);
`else
    run_meas("sq2", 18, 1'b0);
`endif

    // reset in the middle of the gate window discards the measurement
    mode = 1; per = 10;
    repeat (5) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (40) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midrst_count", meas_count, 0);
    chk("midrst_valid", meas_valid, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk); reset = 1'b0;
    saw_valid = 0;
    repeat (G + 20) begin
      @(posedge clk); #1;
      if (meas_valid || busy) saw_valid = 1;
    end
    chk("midrst_no_valid", saw_valid, 0);
    run_meas("after_rst", 10, 1'b0);

    mode = 1; per = 6;
    repeat (7) @(negedge clk);
    run_meas("noise", -1, 1'b1);

    mode = 2;
    for (int r = 0; r < 6; r++) begin
      dens = $urandom_range(90, 10);
      repeat ($urandom_range(15, 3)) @(negedge clk);
      run_meas($sformatf("rnd%0d", r), -1, r[0]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
